// File: rtl/sump_command_decoder_pkg.sv
// Shared definitions for the SUMP command decoder and its neighbours:
// opcode values, the decoder state encoding and the metadata entry
// selectors understood by the metadata transmitter.
package sump_pkg;

  // Short commands (bit 7 clear)
  localparam logic [7:0] CMD_RESET       = 8'h00;
  localparam logic [7:0] CMD_ARM         = 8'h01;
  localparam logic [7:0] CMD_ID          = 8'h02;
  localparam logic [7:0] CMD_METADATA    = 8'h04;

  // Long commands (bit 7 set, four payload bytes follow)
  localparam logic [7:0] CMD_TRIG_MASK   = 8'hC0;
  localparam logic [7:0] CMD_TRIG_VALUE  = 8'hC1;
  localparam logic [7:0] CMD_TRIG_CONFIG = 8'hC2;
  localparam logic [7:0] CMD_DIVIDER     = 8'h80;
  localparam logic [7:0] CMD_COUNTS      = 8'h81;
  localparam logic [7:0] CMD_FLAGS       = 8'h82;

  // Decoder state encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE    = 1'b0;
  localparam state_t ST_COLLECT = 1'b1;

  // Metadata transmitter entry selectors
  localparam logic ENTRY_ID       = 1'b0;
  localparam logic ENTRY_METADATA = 1'b1;

endpackage

// File: rtl/sump_command_decoder_if.sv
// Byte stream from the serial receiver plus the run/finished handshake
// with the metadata transmitter. The master modport is the decoder side.
interface sump_command_decoder_if;

  logic       serial_input_valid;
  logic [7:0] serial_input_data;
  logic       metadata_run;
  logic       metadata_entry;
  logic       metadata_finished;

  modport master (
    input  serial_input_valid,
    input  serial_input_data,
    input  metadata_finished,
    output metadata_run,
    output metadata_entry
  );

  modport slave (
    output serial_input_valid,
    output serial_input_data,
    output metadata_finished,
    input  metadata_run,
    input  metadata_entry
  );

endinterface

// File: rtl/sump_command_decoder.sv
// SUMP host command decoder: assembles 1-byte short commands and 5-byte
// long commands, latches the capture configuration registers and issues
// metadata requests and arm/reset pulses.
// Optional macro SUMP_CMD_TIMEOUT_EN: abandon a partial long command after
// TIMEOUT_CYCLES cycles without a byte.
module sump_command_decoder
  import sump_pkg::*;
#(
  parameter int          CHANNELS       = 8,
  parameter logic [23:0] DIVIDER_RESET  = 24'd0,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  sump_command_decoder_if.master  bus,
  output logic                    arm,
  output logic                    sump_reset,
  output logic [CHANNELS-1:0]     trigger_mask,
  output logic [CHANNELS-1:0]     trigger_value,
  output logic [31:0]             trigger_config,
  output logic [23:0]             sample_divider,
  output logic [15:0]             read_count,
  output logic [15:0]             delay_count,
  output logic [7:0]              flags,
  output logic                    config_strobe
);

  state_t        state_reg;
  logic [7:0]    opcode_reg;
  logic [1:0]    count_reg;
  logic [31:0]   shift_reg;
  logic          busy_reg;
  logic          run_reg;
  logic          entry_reg;
  logic          arm_reg;
  logic          sump_reset_reg;
  logic          strobe_reg;
  logic [CHANNELS-1:0] mask_reg;
  logic [CHANNELS-1:0] value_reg;
  logic [31:0]   config_reg;
  logic [23:0]   divider_reg;
  logic [15:0]   read_count_reg;
  logic [15:0]   delay_count_reg;
  logic [7:0]    flags_reg;

  logic [31:0]   payload_next;
  logic          valid;
  logic          timeout_hit;
  logic          meta_free;

  assign valid = bus.serial_input_valid;
  // Complete payload as it stands once the current byte is shifted in
  assign payload_next = {bus.serial_input_data, shift_reg[31:8]};
  // A finished pulse in the same cycle frees the transmitter for a new request
  assign meta_free = !busy_reg || bus.metadata_finished;

`ifdef SUMP_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] idle_cnt_reg;

  assign timeout_hit = (state_reg == ST_COLLECT) && !valid && (idle_cnt_reg == IDLE_LIMIT);

  // Count idle cycles inside COLLECT; any received byte reloads the count
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_reg <= '0;
    end else if (state_reg != ST_COLLECT || valid) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Command FSM, metadata handshake and configuration register file
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      opcode_reg      <= '0;
      count_reg       <= '0;
      shift_reg       <= '0;
      busy_reg        <= 1'b0;
      run_reg         <= 1'b0;
      entry_reg       <= ENTRY_ID;
      arm_reg         <= 1'b0;
      sump_reset_reg  <= 1'b0;
      strobe_reg      <= 1'b0;
      mask_reg        <= '0;
      value_reg       <= '0;
      config_reg      <= '0;
      divider_reg     <= DIVIDER_RESET;
      read_count_reg  <= '0;
      delay_count_reg <= '0;
      flags_reg       <= '0;
    end else begin
      run_reg        <= 1'b0;
      arm_reg        <= 1'b0;
      sump_reset_reg <= 1'b0;
      strobe_reg     <= 1'b0;
      if (bus.metadata_finished) begin
        busy_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (valid) begin
            if (bus.serial_input_data[7]) begin
              opcode_reg <= bus.serial_input_data;
              count_reg  <= '0;
              state_reg  <= ST_COLLECT;
            end else begin
              case (bus.serial_input_data)
                CMD_RESET: sump_reset_reg <= 1'b1;
                CMD_ARM:   arm_reg        <= 1'b1;
                CMD_ID: begin
                  if (meta_free) begin
                    run_reg   <= 1'b1;
                    entry_reg <= ENTRY_ID;
                    busy_reg  <= 1'b1;
                  end
                end
                CMD_METADATA: begin
                  if (meta_free) begin
                    run_reg   <= 1'b1;
                    entry_reg <= ENTRY_METADATA;
                    busy_reg  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        default: begin
          if (valid) begin
            shift_reg <= payload_next;
            count_reg <= count_reg + 2'd1;
            if (count_reg == 2'd3) begin
              state_reg  <= ST_IDLE;
              strobe_reg <= 1'b1;
              case (opcode_reg)
                CMD_TRIG_MASK:   mask_reg    <= payload_next[CHANNELS-1:0];
                CMD_TRIG_VALUE:  value_reg   <= payload_next[CHANNELS-1:0];
                CMD_TRIG_CONFIG: config_reg  <= payload_next;
                CMD_DIVIDER:     divider_reg <= payload_next[23:0];
                CMD_COUNTS: begin
                  read_count_reg  <= payload_next[15:0];
                  delay_count_reg <= payload_next[31:16];
                end
                CMD_FLAGS:       flags_reg   <= payload_next[7:0];
                default:         strobe_reg  <= 1'b0;
              endcase
            end
          end else if (timeout_hit) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.metadata_run   = run_reg;
  assign bus.metadata_entry = entry_reg;
  assign arm                = arm_reg;
  assign sump_reset         = sump_reset_reg;
  assign config_strobe      = strobe_reg;
  assign trigger_mask       = mask_reg;
  assign trigger_value      = value_reg;
  assign trigger_config     = config_reg;
  assign sample_divider     = divider_reg;
  assign read_count         = read_count_reg;
  assign delay_count        = delay_count_reg;
  assign flags              = flags_reg;

endmodule
